data_memory_sized: RTL and testbench

DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

---
 rtl/data_memory_sized.sv | 141 ++++++++++++++
 tb/tb_data_memory_sized.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory with byte/halfword/word access,
// registered load data, and single-cycle status pulses.
module data_memory_sized #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dm_cs,
   input  logic              dm_wr,
   input  logic              dm_rd,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [31:0]       Addr,
   input  logic [DATA_W-1:0] DM_In,
   output logic [DATA_W-1:0] DM_Out,
   output logic              rd_valid,
   output logic              wr_done,
   output logic              access_err
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("data_memory_sized: DATA_W must be 32");
   end

   typedef enum logic {S_IDLE, S_RESP} state_t;

   logic [7:0]        r_mem [0:(1<<ADDR_W)-1];
   state_t            r_state;
   logic [DATA_W-1:0] r_dmOut;
   logic              r_rdValid;
   logic              r_wrDone;
   logic              r_accErr;

   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] w_addr1;
   logic [ADDR_W-1:0] w_addr2;
   logic [ADDR_W-1:0] w_addr3;
   logic [7:0]        w_b0;
   logic [7:0]        w_b1;
   logic [7:0]        w_b2;
   logic [7:0]        w_b3;
   logic              w_misalign;
   logic              w_badReq;
   logic              w_oneOp;
   logic              w_ldOk;
   logic              w_stOk;
   logic              w_reject;
   logic [31:0]       w_ldData;
   logic              w_unused;

   // Upper address bits alias onto the array.
   assign w_addr   = Addr[ADDR_W-1:0];
   assign w_unused = ^Addr[31:ADDR_W];

   // Accesses are aligned, so the neighbouring bytes are just the low bits set.
   assign w_addr1 = w_addr | ADDR_W'(1);
   assign w_addr2 = w_addr | ADDR_W'(2);
   assign w_addr3 = w_addr | ADDR_W'(3);

   assign w_b0 = r_mem[w_addr];
   assign w_b1 = r_mem[w_addr1];
   assign w_b2 = r_mem[w_addr2];
   assign w_b3 = r_mem[w_addr3];

   assign w_misalign = ((size == 2'b01) && w_addr[0]) ||
                       ((size == 2'b10) && (w_addr[1:0] != 2'b00));
   assign w_badReq   = (size == 2'b11) || w_misalign;
   assign w_oneOp    = dm_rd ^ dm_wr;
   assign w_ldOk     = dm_cs && dm_rd && !dm_wr && !w_badReq;
   assign w_stOk     = dm_cs && dm_wr && !dm_rd && !w_badReq;
   assign w_reject   = dm_cs && ((dm_rd && dm_wr) || (w_oneOp && w_badReq));

   always_comb begin
      w_ldData = {w_b0, w_b1, w_b2, w_b3};
      case (size)
         2'b00:   w_ldData = {{24{sign_ext & w_b0[7]}}, w_b0};
         2'b01:   w_ldData = {{16{sign_ext & w_b0[7]}}, w_b0, w_b1};
         default: w_ldData = {w_b0, w_b1, w_b2, w_b3};
      endcase
   end

   // The array has no reset; stores are simply blocked while reset is held.
   always_ff @(posedge clk) begin
      if (reset_n && w_stOk) begin
         case (size)
            2'b00: r_mem[w_addr] <= DM_In[7:0];
            2'b01: begin
               r_mem[w_addr]  <= DM_In[15:8];
               r_mem[w_addr1] <= DM_In[7:0];
            end
            default: begin
               r_mem[w_addr]  <= DM_In[31:24];
               r_mem[w_addr1] <= DM_In[23:16];
               r_mem[w_addr2] <= DM_In[15:8];
               r_mem[w_addr3] <= DM_In[7:0];
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_dmOut   <= '0;
         r_rdValid <= 1'b0;
         r_wrDone  <= 1'b0;
         r_accErr  <= 1'b0;
      end else begin
         r_wrDone <= w_stOk;
         r_accErr <= w_reject;
         if (w_ldOk) begin
            r_dmOut <= DATA_W'(w_ldData);
         end
         case (r_state)
            S_IDLE: begin
               r_rdValid <= w_ldOk;
               if (w_ldOk) begin
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               r_rdValid <= w_ldOk;
               if (!w_ldOk) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_rdValid <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign DM_Out     = r_dmOut;
   assign rd_valid   = r_rdValid;
   assign wr_done    = r_wrDone;
   assign access_err = r_accErr;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: each driven request queues its
// expected pulses and load data, each feature task drains and compares.
module tb_data_memory_sized;

   logic        clk;
   logic        reset_n;
   logic        dm_cs;
   logic        dm_wr;
   logic        dm_rd;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] Addr;
   logic [31:0] DM_In;
   logic [31:0] DM_Out;
   logic        rd_valid;
   logic        wr_done;
   logic        access_err;

   typedef struct packed {
      logic        rv;
      logic        wd;
      logic        ae;
      logic [31:0] dout;
   } rec_t;

   rec_t        expQ[$];
   rec_t        obsQ[$];
   logic [31:0] modelOut;
   int          checks;
   int          failures;

   data_memory_sized #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .dm_cs      (dm_cs),
      .dm_wr      (dm_wr),
      .dm_rd      (dm_rd),
      .size       (size),
      .sign_ext   (sign_ext),
      .Addr       (Addr),
      .DM_In      (DM_In),
      .DM_Out     (DM_Out),
      .rd_valid   (rd_valid),
      .wr_done    (wr_done),
      .access_err (access_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one request for one clock edge, queues what the spec says should follow it.
   task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                                input logic [1:0] sz, input logic sx,
                                input logic [31:0] addr, input logic [31:0] din,
                                input logic [31:0] expData);
      logic aligned;
      logic ok;
      logic err;
      rec_t e;
      @(negedge clk);
      dm_cs = cs; dm_rd = rd; dm_wr = wr; size = sz; sign_ext = sx;
      Addr = addr; DM_In = din;
      aligned = (sz == 2'd0) || (sz == 2'd1 && !addr[0]) || (sz == 2'd2 && addr[1:0] == 2'd0);
      ok  = cs && (rd != wr) && aligned;
      err = cs && ((rd && wr) || ((rd != wr) && !aligned));
      if (ok && rd) modelOut = expData;
      e.rv = ok && rd;
      e.wd = ok && wr;
      e.ae = err;
      e.dout = modelOut;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      obsQ.push_back({rd_valid, wr_done, access_err, DM_Out});
      dm_cs = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      dm_cs = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; size = 2'd0; sign_ext = 1'b0;
      Addr = '0; DM_In = '0; modelOut = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (DM_Out !== 32'h0) begin failures++; $display("[TB] FAIL reset_dout: got %h want %h", DM_Out, 32'h0); end
      checks++;
      if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rv: got %b want 0", rd_valid); end
      checks++;
      if (wr_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_wd: got %b want 0", wr_done); end
      checks++;
      if (access_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_ae: got %b want 0", access_err); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_word_store_load();
      rec_t e;
      rec_t o;
      applyStimulus(1, 0, 1, 2'd2, 0, 32'h010, 32'h8000_00FF, 32'h0);
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h010, 32'h0, 32'h8000_00FF);
      applyStimulus(1, 1, 0, 2'd0, 1, 32'h010, 32'h0, 32'hFFFF_FF80);
      applyStimulus(1, 1, 0, 2'd1, 1, 32'h010, 32'h0, 32'hFFFF_8000);
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h010, 32'h0, 32'h0);
      for (int i = 0; expQ.size() > 0; i++) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
         if (o !== e) begin failures++;
            $display("[TB] FAIL wordStoreLoad#%0d: got rv=%b wd=%b ae=%b out=%h, want rv=%b wd=%b ae=%b out=%h", i, o.rv, o.wd, o.ae, o.dout, e.rv, e.wd, e.ae, e.dout); end
      end
   endtask

   task automatic test_alias();
      rec_t e;
      rec_t o;
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h0000_1010, 32'h0, 32'h8000_00FF);
      applyStimulus(1, 1, 0, 2'd0, 0, 32'hFFFF_F010, 32'h0, 32'h0000_0080);
      for (int i = 0; expQ.size() > 0; i++) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
         if (o !== e) begin failures++;
            $display("[TB] FAIL alias#%0d: got rv=%b wd=%b ae=%b out=%h, want rv=%b wd=%b ae=%b out=%h", i, o.rv, o.wd, o.ae, o.dout, e.rv, e.wd, e.ae, e.dout); end
      end
   endtask

   task automatic test_byte_store();
      rec_t e;
      rec_t o;
      applyStimulus(1, 0, 1, 2'd0, 0, 32'h013, 32'h1234_56AB, 32'h0);
      applyStimulus(1, 1, 0, 2'd2, 1, 32'h010, 32'h0, 32'h8000_00AB);
      applyStimulus(1, 1, 0, 2'd1, 0, 32'h012, 32'h0, 32'h0000_00AB);
      applyStimulus(1, 1, 0, 2'd0, 1, 32'h013, 32'h0, 32'hFFFF_FFAB);
      applyStimulus(1, 1, 0, 2'd0, 0, 32'h013, 32'h0, 32'h0000_00AB);
      for (int i = 0; expQ.size() > 0; i++) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
         if (o !== e) begin failures++;
            $display("[TB] FAIL byteStore#%0d: got rv=%b wd=%b ae=%b out=%h, want rv=%b wd=%b ae=%b out=%h", i, o.rv, o.wd, o.ae, o.dout, e.rv, e.wd, e.ae, e.dout); end
      end
   endtask

   task automatic test_errors();
      rec_t e;
      rec_t o;
      applyStimulus(1, 0, 1, 2'd2, 0, 32'h020, 32'h5566_7788, 32'h0);
      applyStimulus(1, 1, 1, 2'd2, 0, 32'h020, 32'h1122_3344, 32'h0);
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h020, 32'h0, 32'h5566_7788);
      applyStimulus(1, 0, 1, 2'd2, 0, 32'h011, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(1, 0, 1, 2'd2, 0, 32'h012, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(1, 0, 1, 2'd1, 0, 32'h011, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(1, 1, 0, 2'd1, 0, 32'h003, 32'h0, 32'h0);
      applyStimulus(1, 0, 1, 2'd3, 0, 32'h010, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(1, 1, 0, 2'd3, 0, 32'h010, 32'h0, 32'h0);
      applyStimulus(0, 1, 0, 2'd2, 0, 32'h010, 32'h0, 32'h0);
      applyStimulus(1, 0, 0, 2'd2, 0, 32'h010, 32'h0, 32'h0);
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h010, 32'h0, 32'h8000_00AB);
      for (int i = 0; expQ.size() > 0; i++) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
         if (o !== e) begin failures++;
            $display("[TB] FAIL errors#%0d: got rv=%b wd=%b ae=%b out=%h, want rv=%b wd=%b ae=%b out=%h", i, o.rv, o.wd, o.ae, o.dout, e.rv, e.wd, e.ae, e.dout); end
      end
   endtask

   task automatic test_back_to_back();
      rec_t e;
      rec_t o;
      logic [31:0] words [4];
      words[0] = 32'h0102_0304; words[1] = 32'h1112_1314;
      words[2] = 32'h2122_2324; words[3] = 32'h3132_3334;
      for (int k = 0; k < 4; k++)
         applyStimulus(1, 0, 1, 2'd2, 0, 32'(4 * k), words[k], 32'h0);
      for (int k = 0; k < 4; k++)
         applyStimulus(1, 1, 0, 2'd2, 0, 32'(4 * k), 32'h0, words[k]);
      applyStimulus(1, 0, 1, 2'd2, 0, 32'h00C, 32'hA5A5_5A5A, 32'h0);
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h00C, 32'h0, 32'hA5A5_5A5A);
      applyStimulus(1, 1, 0, 2'd1, 1, 32'h00E, 32'h0, 32'h0000_5A5A);
      applyStimulus(1, 1, 0, 2'd1, 1, 32'h00C, 32'h0, 32'hFFFF_A5A5);
      applyStimulus(1, 1, 0, 2'd0, 0, 32'h00D, 32'h0, 32'h0000_00A5);
      for (int i = 0; expQ.size() > 0; i++) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
         if (o !== e) begin failures++;
            $display("[TB] FAIL backToBack#%0d: got rv=%b wd=%b ae=%b out=%h, want rv=%b wd=%b ae=%b out=%h", i, o.rv, o.wd, o.ae, o.dout, e.rv, e.wd, e.ae, e.dout); end
      end
   endtask

   task automatic test_reset_mid_load();
      rec_t e;
      rec_t o;
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h010, 32'h0, 32'h8000_00AB);
      @(negedge clk);
      dm_cs = 1'b1; dm_rd = 1'b1; dm_wr = 1'b0; size = 2'd2; Addr = 32'h00C;
      @(posedge clk);
      #1;
      dm_cs = 1'b0; dm_rd = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL midReset_rv: got %b want 0", rd_valid); end
      checks++;
      if (DM_Out !== 32'h0) begin failures++; $display("[TB] FAIL midReset_dout: got %h want %h", DM_Out, 32'h0); end
      @(negedge clk);
      dm_cs = 1'b1; dm_wr = 1'b1; size = 2'd2; Addr = 32'h010; DM_In = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      checks++;
      if (wr_done !== 1'b0) begin failures++; $display("[TB] FAIL storeInReset_wd: got %b want 0", wr_done); end
      @(negedge clk);
      dm_cs = 1'b0; dm_wr = 1'b0;
      reset_n = 1'b1;
      modelOut = 32'h0;
      applyStimulus(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0);
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h010, 32'h0, 32'h8000_00AB);
      applyStimulus(1, 1, 0, 2'd2, 0, 32'h008, 32'h0, 32'h2122_2324);
      for (int i = 0; expQ.size() > 0; i++) begin
         e = expQ.pop_front(); o = obsQ.pop_front(); checks++;
         if (o !== e) begin failures++;
            $display("[TB] FAIL resetMidLoad#%0d: got rv=%b wd=%b ae=%b out=%h, want rv=%b wd=%b ae=%b out=%h", i, o.rv, o.wd, o.ae, o.dout, e.rv, e.wd, e.ae, e.dout); end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_word_store_load();
      test_alias();
      test_byte_store();
      test_errors();
      test_back_to_back();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
